// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: MINI-RISC 5-stage hazard controller -- operand forwarding,
// load-use / memory-wait stalls, jump/branch flushes and a stall-cycle counter.
`default_nettype none

module hazard_ctrl_sb #(
  parameter int RA_W     = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  rs1_D_i,
  input  logic [RA_W-1:0]  rs2_D_i,
  input  logic             rs1_used_D_i,
  input  logic             rs2_used_D_i,
  input  logic [RA_W-1:0]  rd_E_i,
  input  logic [RA_W-1:0]  rd_M_i,
  input  logic [RA_W-1:0]  rd_W_i,
  input  logic             reg_write_E_i,
  input  logic             reg_write_M_i,
  input  logic             reg_write_W_i,
  input  logic             mem_read_E_i,
  input  logic             mem_read_M_i,
  input  logic             mem_req_M_i,
  input  logic             mem_ready_M_i,
  input  logic             jump_D_i,
  input  logic             branch_taken_E_i,
  output logic             stall_F_o,
  output logic             stall_D_o,
  output logic             stall_E_o,
  output logic             flush_D_o,
  output logic             flush_E_o,
  output logic [1:0]       forward_A_o,
  output logic [1:0]       forward_B_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LDSTALL = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam bit         LAT_GT1 = (LOAD_LAT > 1);
  localparam logic [1:0] LD_CNT  = 2'(LOAD_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q;

  logic stall_f, stall_d, stall_e, flush_d, flush_e;
  logic mem_block, luh;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic match(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs,
                                 input logic we, input logic used);
    return used & we & (rd != '0) & (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs, input logic used);
    if (match(rd_E_i, rs, reg_write_E_i, used) && !mem_read_E_i)
      return 2'b01;
    else if (match(rd_M_i, rs, reg_write_M_i, used) && !(mem_read_M_i && LAT_GT1))
      return 2'b10;
    else if (match(rd_W_i, rs, reg_write_W_i, used))
      return 2'b11;
    else
      return 2'b00;
  endfunction

  assign luh = mem_read_E_i & (match(rd_E_i, rs1_D_i, reg_write_E_i, rs1_used_D_i) |
                               match(rd_E_i, rs2_D_i, reg_write_E_i, rs2_used_D_i));
  // The very first not-ready cycle already freezes, before MEMWAIT is registered.
  assign mem_block = (state_q == MEMWAIT) | (mem_req_M_i & ~mem_ready_M_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_block) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      cnt_d   = 2'd0;
      state_d = mem_ready_M_i ? RUN : MEMWAIT;
    end else if (branch_taken_E_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      cnt_d   = 2'd0;
      state_d = RUN;
    end else if (state_q == LDSTALL) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      cnt_d   = 2'(cnt_q - 2'd1);
      if (cnt_q == 2'd1)
        state_d = RUN;
    end else begin
      state_d = RUN;
      if (luh) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        if (LAT_GT1) begin
          state_d = LDSTALL;
          cnt_d   = LD_CNT;
        end
      end
      flush_d = jump_D_i & ~stall_d;
    end
  end

  assign fwd_a = stall_d ? 2'b00 : fwd_sel(rs1_D_i, rs1_used_D_i);
  assign fwd_b = stall_d ? 2'b00 : fwd_sel(rs2_D_i, rs2_used_D_i);

  // Outputs are gated by rst_n so an asserted reset releases everything at once.
  assign stall_F_o     = rst_n & stall_f;
  assign stall_D_o     = rst_n & stall_d;
  assign stall_E_o     = rst_n & stall_e;
  assign flush_D_o     = rst_n & flush_d;
  assign flush_E_o     = rst_n & flush_e;
  assign forward_A_o   = rst_n ? fwd_a : 2'b00;
  assign forward_B_o   = rst_n ? fwd_b : 2'b00;
  assign stall_count_o = stall_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_d && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: table-driven and sequence checks of hazard_ctrl_sb with
// two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=2) on shared inputs.
`default_nettype none

module tb_hazard_ctrl_sb;

  typedef struct packed {
    logic [2:0] rs1, rs2, rdE, rdM, rdW;
    logic u1, u2, weE, weM, weW, mrE, mrM, req, rdy, jmp, br;
  } in_t;

  typedef struct packed {
    logic sF, sD, sE, fD, fE;
    logic [1:0] fA, fB;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t e1;
    out_t e3;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  drv = '0;

  logic sF1, sD1, sE1, fD1, fE1, sF3, sD3, sE3, fD3, fE3;
  logic [1:0] fA1, fB1, fA3, fB3;
  logic [15:0] cnt1;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;
  out_t q1[$];
  out_t q3[$];

  always #5 clk = ~clk;

  hazard_ctrl_sb #(.RA_W(3), .LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D_i(drv.rs1), .rs2_D_i(drv.rs2), .rs1_used_D_i(drv.u1), .rs2_used_D_i(drv.u2),
    .rd_E_i(drv.rdE), .rd_M_i(drv.rdM), .rd_W_i(drv.rdW),
    .reg_write_E_i(drv.weE), .reg_write_M_i(drv.weM), .reg_write_W_i(drv.weW),
    .mem_read_E_i(drv.mrE), .mem_read_M_i(drv.mrM),
    .mem_req_M_i(drv.req), .mem_ready_M_i(drv.rdy),
    .jump_D_i(drv.jmp), .branch_taken_E_i(drv.br),
    .stall_F_o(sF1), .stall_D_o(sD1), .stall_E_o(sE1), .flush_D_o(fD1), .flush_E_o(fE1),
    .forward_A_o(fA1), .forward_B_o(fB1), .stall_count_o(cnt1)
  );

  hazard_ctrl_sb #(.RA_W(3), .LOAD_LAT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .rs1_D_i(drv.rs1), .rs2_D_i(drv.rs2), .rs1_used_D_i(drv.u1), .rs2_used_D_i(drv.u2),
    .rd_E_i(drv.rdE), .rd_M_i(drv.rdM), .rd_W_i(drv.rdW),
    .reg_write_E_i(drv.weE), .reg_write_M_i(drv.weM), .reg_write_W_i(drv.weW),
    .mem_read_E_i(drv.mrE), .mem_read_M_i(drv.mrM),
    .mem_req_M_i(drv.req), .mem_ready_M_i(drv.rdy),
    .jump_D_i(drv.jmp), .branch_taken_E_i(drv.br),
    .stall_F_o(sF3), .stall_D_o(sD3), .stall_E_o(sE3), .flush_D_o(fD3), .flush_E_o(fE3),
    .forward_A_o(fA3), .forward_B_o(fB3), .stall_count_o(cnt3)
  );

  function automatic in_t mk(input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic u1, input logic u2,
                             input logic [2:0] rdE, input logic [2:0] rdM, input logic [2:0] rdW,
                             input logic weE, input logic weM, input logic weW,
                             input logic mrE, input logic mrM, input logic jmp, input logic br);
    in_t r;
    r = '0;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rdE = rdE; r.rdM = rdM; r.rdW = rdW;
    r.weE = weE; r.weM = weM; r.weW = weW;
    r.mrE = mrE; r.mrM = mrM; r.jmp = jmp; r.br = br;
    return r;
  endfunction

  function automatic out_t o(input logic sF, input logic sD, input logic sE, input logic fD,
                             input logic fE, input logic [1:0] a, input logic [1:0] b);
    out_t r;
    r.sF = sF; r.sD = sD; r.sE = sE; r.fD = fD; r.fE = fE; r.fA = a; r.fB = b;
    return r;
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got sF/sD/sE/fD/fE/fA/fB=%b required=%b", name, got, exp);
    end
  endtask

  task automatic cmp_cnt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: stall_count got=%0d required=%0d", name, got, exp);
    end
  endtask

  // Pop both scoreboards and compare against the live DUT outputs.
  task automatic check_now(input string name);
    out_t e1, e3;
    if (q1.size() == 0 || q3.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e1 = q1.pop_front();
      e3 = q3.pop_front();
      cmp({name, "/lat1"}, out_t'({sF1, sD1, sE1, fD1, fE1, fA1, fB1}), e1);
      cmp({name, "/lat3"}, out_t'({sF3, sD3, sE3, fD3, fE3, fA3, fB3}), e3);
    end
  endtask

  task automatic step(input string name, input in_t i, input out_t e1, input out_t e3);
    @(posedge clk);
    #1;
    drv = i;
    q1.push_back(e1);
    q3.push_back(e3);
    @(negedge clk);
    check_now(name);
  endtask

  out_t Z, STL, MW, BR, JMP;
  in_t  IDLE, LUH, MEMNR, MEMR, BRI;
  vec_t tbl[12];

  initial begin
    Z   = o(0, 0, 0, 0, 0, 2'b00, 2'b00);
    STL = o(1, 1, 0, 0, 1, 2'b00, 2'b00);
    MW  = o(1, 1, 1, 0, 0, 2'b00, 2'b00);
    BR  = o(0, 0, 0, 1, 1, 2'b00, 2'b00);
    JMP = o(0, 0, 0, 1, 0, 2'b00, 2'b00);
    IDLE = '0;
    LUH  = mk(3'd2, 3'd0, 1, 0, 3'd2, 3'd0, 3'd0, 1, 0, 0, 1, 0, 0, 0);
    BRI  = mk(3'd0, 3'd0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
    MEMNR = BRI; MEMNR.req = 1'b1; MEMNR.rdy = 1'b0;
    MEMR  = BRI; MEMR.req  = 1'b1; MEMR.rdy  = 1'b1;

    tbl[0]  = '{IDLE, Z, Z};
    tbl[1]  = '{mk(3, 0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                o(0, 0, 0, 0, 0, 2'b01, 2'b00), o(0, 0, 0, 0, 0, 2'b01, 2'b00)};
    tbl[2]  = '{mk(0, 3, 0, 1, 0, 3, 3, 0, 1, 1, 0, 0, 0, 0),
                o(0, 0, 0, 0, 0, 2'b00, 2'b10), o(0, 0, 0, 0, 0, 2'b00, 2'b10)};
    tbl[3]  = '{mk(5, 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0),
                o(0, 0, 0, 0, 0, 2'b11, 2'b00), o(0, 0, 0, 0, 0, 2'b11, 2'b00)};
    tbl[4]  = '{mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), Z, Z};
    tbl[5]  = '{mk(3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0), Z, Z};
    tbl[6]  = '{mk(4, 0, 1, 0, 0, 4, 4, 0, 1, 1, 0, 1, 0, 0),
                o(0, 0, 0, 0, 0, 2'b10, 2'b00), o(0, 0, 0, 0, 0, 2'b11, 2'b00)};
    tbl[7]  = '{mk(2, 0, 1, 0, 3, 2, 0, 1, 1, 0, 1, 0, 0, 0),
                o(0, 0, 0, 0, 0, 2'b10, 2'b00), o(0, 0, 0, 0, 0, 2'b10, 2'b00)};
    tbl[8]  = '{mk(3, 3, 1, 1, 3, 3, 0, 1, 1, 0, 0, 0, 0, 0),
                o(0, 0, 0, 0, 0, 2'b01, 2'b01), o(0, 0, 0, 0, 0, 2'b01, 2'b01)};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), JMP, JMP};
    tbl[10] = '{BRI, BR, BR};
    tbl[11] = '{mk(3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z};

    // Reset: everything quiet even with hazards on the inputs.
    drv = LUH; drv.jmp = 1'b1; drv.br = 1'b1; drv.req = 1'b1;
    #3;
    q1.push_back(Z); q3.push_back(Z);
    check_now("reset_outputs");
    cmp_cnt("reset_cnt1", int'(cnt1), 0);
    cmp_cnt("reset_cnt3", int'(cnt3), 0);
    @(negedge clk);
    drv = IDLE;
    rst_n = 1'b1;

    foreach (tbl[k]) step($sformatf("vec%0d", k), tbl[k].in, tbl[k].e1, tbl[k].e3);

    // Load-use: 1 stall cycle at LOAD_LAT=1, 3 at LOAD_LAT=3.
    step("lu_c1", LUH, STL, STL);
    step("lu_c2", mk(2, 0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 1, 0, 0),
         o(0, 0, 0, 0, 0, 2'b10, 2'b00), STL);
    step("lu_c3", mk(2, 0, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0),
         o(0, 0, 0, 0, 0, 2'b11, 2'b00), STL);
    step("lu_c4", mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z, Z);
    cmp_cnt("lu_cnt1", int'(cnt1), 1);
    cmp_cnt("lu_cnt3", int'(cnt3), 3);

    // Memory wait 4 cycles + ready cycle, branch held throughout.
    for (int k = 0; k < 4; k++) step($sformatf("mw_wait%0d", k), MEMNR, MW, MW);
    step("mw_ready", MEMR, MW, MW);
    step("mw_after_br", BRI, BR, BR);
    step("mw_idle", IDLE, Z, Z);
    cmp_cnt("mw_cnt1", int'(cnt1), 6);
    cmp_cnt("mw_cnt3_sat", int'(cnt3), 3);

    // Branch overrides LDSTALL; jump suppressed while stalled.
    step("br_lu", LUH, STL, STL);
    step("br_in_ldstall", BRI, BR, BR);
    step("br_idle", IDLE, Z, Z);
    begin
      in_t lj;
      lj = LUH; lj.jmp = 1'b1;
      step("jmp_luh", lj, STL, STL);
    end
    step("jmp_ldstall", tbl[9].in, JMP, STL);
    step("ldstall_last", IDLE, Z, STL);
    step("ldstall_done", IDLE, Z, Z);
    cmp_cnt("jb_cnt1", int'(cnt1), 8);

    // Asynchronous reset mid-LDSTALL.
    step("ar_lu", LUH, STL, STL);
    @(posedge clk);
    #1;
    drv = LUH;
    #2;
    q1.push_back(STL); q3.push_back(STL);
    check_now("ar_pre");
    rst_n = 1'b0;
    #1;
    q1.push_back(Z); q3.push_back(Z);
    check_now("ar_async");
    cmp_cnt("ar_cnt1", int'(cnt1), 0);
    cmp_cnt("ar_cnt3", int'(cnt3), 0);
    @(negedge clk);
    drv = IDLE;
    rst_n = 1'b1;
    step("ar_release", IDLE, Z, Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
